// File: rtl/dsp_mac_sequencer.sv
// -----------------------------------------------------------------------------
// dsp_mac_sequencer
//
// Control sequencer for a DSP48A1-style multiply-accumulate slice computing an
// N-term dot product.  The block carries no data: operands go straight from
// the upstream source to the slice A/B pins.  This block only generates the
// slice clock enables, OPMODE and P-register reset, so that P holds sum(A*B)
// when result_valid rises.
//
// Slice configuration assumed: AREG = BREG = 1, MREG = 1, PREG = 1,
// OPMODEREG = 0 (opmode is consumed combinationally in the same cycle as cep).
//
// Handshake: an operand beat transfers in a cycle where in_valid & in_ready
// are both 1.  in_ready is high only in RUN and is forced low in any cycle
// where abort is high.  The result is offered with result_valid (held while in
// DONE) and is consumed in the cycle where result_valid & result_ready are 1.
//
// Ports:
//   clk           rising-edge clock
//   rst_aSYNC     asynchronous, active-high reset
//   start, len    job request and length in beats (sampled only in IDLE)
//   abort         cancel the current job (ignored in IDLE)
//   in_valid      upstream operand pair valid on slice A/B pins
//   in_ready      beat accepted when in_valid & in_ready
//   result_ready  consumer acknowledge of the result
//   cea, ceb      slice A/B register enables
//   cem           slice M register enable
//   cep           slice P register enable
//   rst_p         slice P register reset, one-cycle pulse after an abort
//   opmode        slice OPMODE: 8'h01 = M (first product), 8'h09 = P + M
//   busy          state is not IDLE
//   result_valid  P holds the final sum
//   beats_left    beats still to accept in the current job
//   state_dbg     current FSM state (0 IDLE, 1 RUN, 2 DRAIN, 3 DONE)
// -----------------------------------------------------------------------------
module dsp_mac_sequencer #(
    parameter int LEN_WIDTH = 8
) (
    input  logic                 clk,
    input  logic                 rst_aSYNC,
    input  logic                 start,
    input  logic [LEN_WIDTH-1:0] len,
    input  logic                 abort,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic                 result_ready,
    output logic                 cea,
    output logic                 ceb,
    output logic                 cem,
    output logic                 cep,
    output logic                 rst_p,
    output logic [7:0]           opmode,
    output logic                 busy,
    output logic                 result_valid,
    output logic [LEN_WIDTH-1:0] beats_left,
    output logic [1:0]           state_dbg
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_RUN   = 2'd1,
        S_DRAIN = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    localparam logic [7:0] OPMODE_M      = 8'h01;  // Z = 0, X = M
    localparam logic [7:0] OPMODE_P_PLUS = 8'h09;  // Z = P, X = M

    state_t state;

    // Pipeline tracker: v1/f1 mirror the beat sitting in the A/B registers
    // (about to be multiplied), v2/f2 the product sitting in the M register
    // (about to be accumulated).  f marks the first beat of the job.
    logic v1;
    logic v2;
    logic f1;
    logic f2;

    // Set on job load, cleared when the first beat is accepted.
    logic first_pending;

    logic accept;
    logic abort_hit;

    // abort blocks acceptance combinationally so an abort-cycle beat never
    // enters the slice.
    assign in_ready  = (state == S_RUN) && !abort;
    assign accept    = in_valid && in_ready;
    assign abort_hit = abort && (state != S_IDLE);

    assign cea = accept;
    assign ceb = accept;
    assign cem = v1;
    assign cep = v2;

    // The first product overwrites P, so no clear is needed between jobs.
    assign opmode = (v2 && f2) ? OPMODE_M : OPMODE_P_PLUS;

    assign state_dbg = state;

    always_ff @(posedge clk or posedge rst_aSYNC) begin
        if (rst_aSYNC) begin
            state         <= S_IDLE;
            busy          <= 1'b0;
            result_valid  <= 1'b0;
            rst_p         <= 1'b0;
            beats_left    <= '0;
            first_pending <= 1'b0;
            v1            <= 1'b0;
            v2            <= 1'b0;
            f1            <= 1'b0;
            f2            <= 1'b0;
        end else begin
            rst_p <= 1'b0;

            // Tracker advances every cycle; it only fills while in RUN.
            v1 <= accept;
            f1 <= accept && first_pending;
            v2 <= v1;
            f2 <= f1;

            if (abort_hit) begin
                // Abort wins over everything else this cycle: drop the job,
                // flush in-flight beats and clear P on the next cycle.
                state         <= S_IDLE;
                busy          <= 1'b0;
                result_valid  <= 1'b0;
                rst_p         <= 1'b1;
                beats_left    <= '0;
                first_pending <= 1'b0;
                v1            <= 1'b0;
                v2            <= 1'b0;
                f1            <= 1'b0;
                f2            <= 1'b0;
            end else begin
                case (state)
                    S_IDLE: begin
                        if (start && (len != '0) && !abort) begin
                            state         <= S_RUN;
                            busy          <= 1'b1;
                            beats_left    <= len;
                            first_pending <= 1'b1;
                        end
                    end

                    S_RUN: begin
                        if (accept) begin
                            beats_left    <= beats_left - LEN_WIDTH'(1);
                            first_pending <= 1'b0;
                            if (beats_left == LEN_WIDTH'(1)) begin
                                state <= S_DRAIN;
                            end
                        end
                    end

                    S_DRAIN: begin
                        // No new beats enter in DRAIN, so once v1 is empty the
                        // tracker is empty after this edge; the last product
                        // lands in P at this same edge.
                        if (!v1) begin
                            state        <= S_DONE;
                            result_valid <= 1'b1;
                        end
                    end

                    S_DONE: begin
                        if (result_ready) begin
                            state        <= S_IDLE;
                            busy         <= 1'b0;
                            result_valid <= 1'b0;
                        end
                    end

                    default: begin
                        state        <= S_IDLE;
                        busy         <= 1'b0;
                        result_valid <= 1'b0;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_dsp_mac_sequencer.sv
// -----------------------------------------------------------------------------
// tb_dsp_mac_sequencer
//
// Directed bench for dsp_mac_sequencer.  A small behavioural model of the
// DSP slice (A/B register, M register, P register with OPMODE Z/X select)
// is driven by the sequencer outputs so the final P value can be compared
// against hand-computed dot products.  Each scenario task counts cycles from
// the start request (cycle 0), drives inputs 1 ns after the rising edge and
// samples outputs on the falling edge.
// -----------------------------------------------------------------------------
module tb_dsp_mac_sequencer;

    localparam int LW = 8;

    // Clock / reset
    logic clk = 1'b0;
    logic rst_aSYNC = 1'b1;
    always #5 clk = ~clk;

    // DUT signals
    logic          start = 1'b0;
    logic [LW-1:0] len = '0;
    logic          abort = 1'b0;
    logic          in_valid = 1'b0;
    logic          in_ready;
    logic          result_ready = 1'b0;
    logic          cea;
    logic          ceb;
    logic          cem;
    logic          cep;
    logic          rst_p;
    logic [7:0]    opmode;
    logic          busy;
    logic          result_valid;
    logic [LW-1:0] beats_left;
    logic [1:0]    state_dbg;

    dsp_mac_sequencer #(.LEN_WIDTH(LW)) dut (
        .clk          (clk),
        .rst_aSYNC    (rst_aSYNC),
        .start        (start),
        .len          (len),
        .abort        (abort),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .result_ready (result_ready),
        .cea          (cea),
        .ceb          (ceb),
        .cem          (cem),
        .cep          (cep),
        .rst_p        (rst_p),
        .opmode       (opmode),
        .busy         (busy),
        .result_valid (result_valid),
        .beats_left   (beats_left),
        .state_dbg    (state_dbg)
    );

    // Behavioural slice: AREG/BREG = 1, MREG = 1, PREG = 1, OPMODEREG = 0
    logic [7:0]  a_in = '0;
    logic [7:0]  b_in = '0;
    logic [7:0]  a_r = '0;
    logic [7:0]  b_r = '0;
    logic [15:0] m_r = '0;
    logic [31:0] p_r = '0;

    always @(posedge clk) begin
        if (cea) a_r <= a_in;
        if (ceb) b_r <= b_in;
        if (cem) m_r <= a_r * b_r;
        if (rst_p)
            p_r <= '0;
        else if (cep)
            p_r <= ((opmode[3:2] == 2'b10) ? p_r : 32'd0) +
                   ((opmode[1:0] == 2'b01) ? 32'(m_r) : 32'd0);
    end

    int   errors = 0;
    int   checks = 0;
    logic exp_b;
    logic [7:0] exp_op;

    task automatic test_reset();
        rst_aSYNC = 1'b1;
        repeat (2) @(negedge clk);
        checks++; if (busy !== 1'b0 || result_valid !== 1'b0 || in_ready !== 1'b0) begin
            errors++; $display("FAIL reset_status got busy=%b rv=%b rdy=%b exp 0 0 0", busy, result_valid, in_ready);
        end
        checks++; if ({cea, ceb, cem, cep, rst_p} !== 5'b0) begin
            errors++; $display("FAIL reset_enables got %b exp 00000", {cea, ceb, cem, cep, rst_p});
        end
        checks++; if (opmode !== 8'h09 || beats_left !== '0) begin
            errors++; $display("FAIL reset_opmode_beats got op=%h bl=%0d exp 09 0", opmode, beats_left);
        end
        #3 rst_aSYNC = 1'b0;
    endtask

    // len = 4, in_valid held high, A*B = 1,2,3,4 -> P = 10
    task automatic test_basic();
        for (int c = 0; c <= 8; c++) begin
            @(posedge clk); #1;
            start = (c == 0); len = 8'd4; abort = 1'b0;
            in_valid = (c <= 6); a_in = 8'(c); b_in = 8'd1;
            result_ready = (c == 7);
            @(negedge clk);
            exp_b = (c >= 1 && c <= 4);
            checks++; if (cea !== exp_b) begin errors++; $display("FAIL basic_cea c=%0d got=%b exp=%b", c, cea, exp_b); end
            exp_b = (c >= 3 && c <= 6);
            checks++; if (cep !== exp_b) begin errors++; $display("FAIL basic_cep c=%0d got=%b exp=%b", c, cep, exp_b); end
            if (c >= 3 && c <= 6) begin
                exp_op = (c == 3) ? 8'h01 : 8'h09;
                checks++; if (opmode !== exp_op) begin errors++; $display("FAIL basic_opmode c=%0d got=%h exp=%h", c, opmode, exp_op); end
            end
            exp_b = (c == 7);
            checks++; if (result_valid !== exp_b) begin errors++; $display("FAIL basic_rv c=%0d got=%b exp=%b", c, result_valid, exp_b); end
            exp_b = (c >= 1 && c <= 7);
            checks++; if (busy !== exp_b) begin errors++; $display("FAIL basic_busy c=%0d got=%b exp=%b", c, busy, exp_b); end
            if (c == 7) begin
                checks++; if (p_r !== 32'd10) begin errors++; $display("FAIL basic_p got=%0d exp=10", p_r); end
            end
        end
    endtask

    // len = 3, beats at cycles 1,4,6 with A*B = 6,15,21 -> P = 42
    task automatic test_gaps();
        for (int c = 0; c <= 10; c++) begin
            @(posedge clk); #1;
            start = (c == 0); len = 8'd3; abort = 1'b0;
            in_valid = (c == 1 || c == 4 || c == 6);
            a_in = (c == 1) ? 8'd2 : (c == 4) ? 8'd5 : 8'd7; b_in = 8'd3;
            result_ready = (c == 9);
            @(negedge clk);
            exp_b = (c == 1 || c == 4 || c == 6);
            checks++; if (cea !== exp_b) begin errors++; $display("FAIL gaps_cea c=%0d got=%b exp=%b", c, cea, exp_b); end
            exp_b = (c == 3 || c == 6 || c == 8);
            checks++; if (cep !== exp_b) begin errors++; $display("FAIL gaps_cep c=%0d got=%b exp=%b", c, cep, exp_b); end
            if (c >= 3 && c <= 8) begin
                exp_op = (c == 3) ? 8'h01 : 8'h09;
                checks++; if (opmode !== exp_op) begin errors++; $display("FAIL gaps_opmode c=%0d got=%h exp=%h", c, opmode, exp_op); end
            end
            if (c == 4 || c == 5) begin
                checks++; if (p_r !== 32'd6) begin errors++; $display("FAIL gaps_p_hold c=%0d got=%0d exp=6", c, p_r); end
            end
            if (c == 5) begin
                checks++; if (beats_left !== 8'd1) begin errors++; $display("FAIL gaps_beats_left got=%0d exp=1", beats_left); end
            end
            if (c == 7) begin
                checks++; if (p_r !== 32'd21) begin errors++; $display("FAIL gaps_p_mid got=%0d exp=21", p_r); end
            end
            exp_b = (c == 9);
            checks++; if (result_valid !== exp_b) begin errors++; $display("FAIL gaps_rv c=%0d got=%b exp=%b", c, result_valid, exp_b); end
            if (c == 9) begin
                checks++; if (p_r !== 32'd42) begin errors++; $display("FAIL gaps_p got=%0d exp=42", p_r); end
            end
            if (c == 10) begin
                checks++; if (busy !== 1'b0) begin errors++; $display("FAIL gaps_idle got busy=%b exp=0", busy); end
            end
        end
    endtask

    // len = 1, 9*9 = 81; result held 5 cycles by result_ready = 0
    task automatic test_len_one();
        for (int c = 0; c <= 9; c++) begin
            @(posedge clk); #1;
            start = (c == 0); len = 8'd1; abort = 1'b0;
            in_valid = (c == 1); a_in = 8'd9; b_in = 8'd9;
            result_ready = (c == 8);
            @(negedge clk);
            exp_b = (c == 3);
            checks++; if (cep !== exp_b) begin errors++; $display("FAIL one_cep c=%0d got=%b exp=%b", c, cep, exp_b); end
            if (c == 3) begin
                checks++; if (opmode !== 8'h01) begin errors++; $display("FAIL one_opmode got=%h exp=01", opmode); end
            end
            exp_b = (c >= 4 && c <= 8);
            checks++; if (result_valid !== exp_b) begin errors++; $display("FAIL one_rv c=%0d got=%b exp=%b", c, result_valid, exp_b); end
            if (c == 4) begin
                checks++; if (p_r !== 32'd81) begin errors++; $display("FAIL one_p got=%0d exp=81", p_r); end
            end
            if (c == 9) begin
                checks++; if (busy !== 1'b0) begin errors++; $display("FAIL one_idle got busy=%b exp=0", busy); end
            end
        end
    endtask

    // len = 0 ignored; start while busy ignored
    task automatic test_ignored_starts();
        for (int c = 0; c <= 3; c++) begin
            @(posedge clk); #1;
            start = (c == 0); len = 8'd0; abort = 1'b0;
            in_valid = 1'b1; result_ready = 1'b0;
            @(negedge clk);
            checks++; if ({busy, cea, cem, cep} !== 4'b0) begin
                errors++; $display("FAIL zero_len c=%0d got busy,cea,cem,cep=%b exp=0000", c, {busy, cea, cem, cep});
            end
        end
        // A*B = 4*2, 5*2, 6*2 -> P = 30
        for (int c = 0; c <= 10; c++) begin
            @(posedge clk); #1;
            start = (c == 0 || c == 2); len = (c == 0) ? 8'd3 : 8'd7; abort = 1'b0;
            in_valid = (c >= 4 && c <= 6); a_in = 8'(c); b_in = 8'd2;
            result_ready = (c == 9);
            @(negedge clk);
            if (c >= 1 && c <= 4) begin
                checks++; if (beats_left !== 8'd3) begin errors++; $display("FAIL busy_start_bl c=%0d got=%0d exp=3", c, beats_left); end
            end
            if (c == 5) begin
                checks++; if (beats_left !== 8'd2) begin errors++; $display("FAIL busy_start_dec got=%0d exp=2", beats_left); end
            end
            exp_b = (c == 9);
            checks++; if (result_valid !== exp_b) begin errors++; $display("FAIL busy_start_rv c=%0d got=%b exp=%b", c, result_valid, exp_b); end
            if (c == 9) begin
                checks++; if (p_r !== 32'd30) begin errors++; $display("FAIL busy_start_p got=%0d exp=30", p_r); end
            end
            if (c == 10) begin
                checks++; if (busy !== 1'b0) begin errors++; $display("FAIL busy_start_idle got=%b exp=0", busy); end
            end
        end
    endtask

    // len = 5, abort in cycle 3 after beats at cycles 1 and 2
    task automatic test_abort();
        for (int c = 0; c <= 10; c++) begin
            @(posedge clk); #1;
            start = (c == 0); len = 8'd5; abort = (c == 3);
            in_valid = (c >= 1 && c <= 8); a_in = 8'(c); b_in = 8'd1;
            result_ready = 1'b0;
            @(negedge clk);
            if (c == 2) begin
                checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL abort_pre_ready got=%b exp=1", in_ready); end
            end
            if (c == 3) begin
                checks++; if (in_ready !== 1'b0 || cea !== 1'b0) begin
                    errors++; $display("FAIL abort_cycle_ready got rdy=%b cea=%b exp 0 0", in_ready, cea);
                end
            end
            exp_b = (c == 4);
            checks++; if (rst_p !== exp_b) begin errors++; $display("FAIL abort_rst_p c=%0d got=%b exp=%b", c, rst_p, exp_b); end
            if (c >= 4) begin
                checks++; if ({busy, cea, cem, cep} !== 4'b0) begin
                    errors++; $display("FAIL abort_idle c=%0d got busy,cea,cem,cep=%b exp=0000", c, {busy, cea, cem, cep});
                end
            end
            if (c == 4) begin
                checks++; if (beats_left !== 8'd0) begin errors++; $display("FAIL abort_bl got=%0d exp=0", beats_left); end
            end
            if (c == 5) begin
                checks++; if (p_r !== 32'd0) begin errors++; $display("FAIL abort_p_clear got=%0d exp=0", p_r); end
            end
            checks++; if (result_valid !== 1'b0) begin errors++; $display("FAIL abort_rv c=%0d got=%b exp=0", c, result_valid); end
        end
    endtask

    // Reset mid-DRAIN at a non-edge time, then a fresh len = 2 job: 4*5 + 6*7 = 62
    task automatic test_async_reset();
        for (int c = 0; c <= 3; c++) begin
            @(posedge clk); #1;
            start = (c == 0); len = 8'd2; abort = 1'b0;
            in_valid = (c == 1 || c == 2); a_in = 8'd3; b_in = 8'd3;
            result_ready = 1'b0;
            if (c == 3) begin
                #1;
                checks++; if (state_dbg !== 2'd2 || cem !== 1'b1) begin
                    errors++; $display("FAIL areset_in_drain got state=%0d cem=%b exp 2 1", state_dbg, cem);
                end
                #1 rst_aSYNC = 1'b1;
                #1;
                checks++; if ({busy, result_valid, in_ready, cea, ceb, cem, cep, rst_p} !== 8'b0) begin
                    errors++; $display("FAIL areset_outputs got %b exp 00000000",
                                       {busy, result_valid, in_ready, cea, ceb, cem, cep, rst_p});
                end
                checks++; if (opmode !== 8'h09 || beats_left !== 8'd0 || state_dbg !== 2'd0) begin
                    errors++; $display("FAIL areset_regs got op=%h bl=%0d st=%0d exp 09 0 0", opmode, beats_left, state_dbg);
                end
            end
        end
        in_valid = 1'b0; start = 1'b0;
        @(posedge clk); #4 rst_aSYNC = 1'b0;
        for (int c = 0; c <= 6; c++) begin
            @(posedge clk); #1;
            start = (c == 0); len = 8'd2; abort = 1'b0;
            in_valid = (c == 1 || c == 2);
            a_in = (c == 1) ? 8'd4 : 8'd6; b_in = (c == 1) ? 8'd5 : 8'd7;
            result_ready = (c == 5);
            @(negedge clk);
            exp_b = (c == 5);
            checks++; if (result_valid !== exp_b) begin errors++; $display("FAIL areset_job_rv c=%0d got=%b exp=%b", c, result_valid, exp_b); end
            if (c == 5) begin
                checks++; if (p_r !== 32'd62) begin errors++; $display("FAIL areset_job_p got=%0d exp=62", p_r); end
            end
            if (c == 6) begin
                checks++; if (busy !== 1'b0) begin errors++; $display("FAIL areset_job_idle got=%b exp=0", busy); end
            end
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_gaps();
        test_len_one();
        test_ignored_starts();
        test_abort();
        test_async_reset();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
